// File: rtl/fwd_result_pipe_if.sv
// Bundles the issue, lookup and writeback signals of the forwarding pipe.
// The master drives packets and lookup addresses; the slave is the pipe itself.
interface fwd_result_pipe_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int LAT_W  = 4,
    parameter int NUM_RD = 3
) ();
    logic [LANES-1:0]          in_valid;
    logic [LANES-1:0]          in_wr_en;
    logic [LANES*ADDR_W-1:0]   in_addr;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [LANES*LAT_W-1:0]    in_lat;
    logic                      stall;
    logic                      flush;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0]         rd_hit;
    logic [NUM_RD-1:0]         rd_pending;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [LANES-1:0]          wb_valid;
    logic [LANES*ADDR_W-1:0]   wb_addr;
    logic [LANES*DATA_W-1:0]   wb_data;

    modport master (
        output in_valid, in_wr_en, in_addr, in_data, in_lat, stall, flush, rd_addr,
        input  rd_hit, rd_pending, rd_data, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_wr_en, in_addr, in_data, in_lat, stall, flush, rd_addr,
        output rd_hit, rd_pending, rd_data, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/fwd_result_pipe.sv
// Per-lane result shift pipe with youngest-first operand forwarding and
// register-file writeback from the last stage. Array index s holds stage s+1.
module fwd_result_pipe #(
    parameter int LANES        = 2,
    parameter int DEPTH        = 7,
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 7,
    parameter int LAT_W        = 4,
    parameter int NUM_RD       = 3,
    parameter int FLUSH_STAGES = 1
) (
    input logic              clock,
    input logic              reset,
    fwd_result_pipe_if.slave bus
);

    logic [LANES-1:0][DEPTH-1:0]             st_valid;
    logic [LANES-1:0][DEPTH-1:0]             st_wr_en;
    logic [LANES-1:0][DEPTH-1:0][ADDR_W-1:0] st_addr;
    logic [LANES-1:0][DEPTH-1:0][DATA_W-1:0] st_data;
    logic [LANES-1:0][DEPTH-1:0][LAT_W-1:0]  st_lat;

    logic [NUM_RD-1:0]        lk_hit;
    logic [NUM_RD-1:0]        lk_pending;
    logic [NUM_RD*DATA_W-1:0] lk_data;
    logic [LANES-1:0]         wbk_valid;
    logic [LANES*ADDR_W-1:0]  wbk_addr;
    logic [LANES*DATA_W-1:0]  wbk_data;

    // Shift every lane one stage when not stalled; flush then kills the youngest
    // stages (after the shift, or in place when stalled), which also drops the input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
            st_wr_en <= '0;
            st_addr  <= '0;
            st_data  <= '0;
            st_lat   <= '0;
        end else begin
            if (!bus.stall) begin
                for (int l = 0; l < LANES; l++) begin
                    st_valid[l][0] <= bus.in_valid[l];
                    st_wr_en[l][0] <= bus.in_wr_en[l];
                    st_addr[l][0]  <= bus.in_addr[l*ADDR_W +: ADDR_W];
                    st_data[l][0]  <= bus.in_data[l*DATA_W +: DATA_W];
                    st_lat[l][0]   <= bus.in_lat[l*LAT_W +: LAT_W];
                    for (int s = 1; s < DEPTH; s++) begin
                        st_valid[l][s] <= st_valid[l][s-1];
                        st_wr_en[l][s] <= st_wr_en[l][s-1];
                        st_addr[l][s]  <= st_addr[l][s-1];
                        st_data[l][s]  <= st_data[l][s-1];
                        st_lat[l][s]   <= st_lat[l][s-1];
                    end
                end
            end
            if (bus.flush) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        if (s < FLUSH_STAGES) begin
                            st_valid[l][s] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Forwarding lookup: the first candidate in youngest-first order decides the
    // outcome, so an older ready copy never shadows a younger in-flight result.
    always_comb begin
        logic found;
        found      = 1'b0;
        lk_hit     = '0;
        lk_pending = '0;
        lk_data    = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            found = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                for (int l = LANES - 1; l >= 0; l--) begin
                    if (!found && st_valid[l][s] && st_wr_en[l][s] &&
                        st_addr[l][s] == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
                        found = 1'b1;
                        if (int'(st_lat[l][s]) <= s + 1) begin
                            lk_hit[p]                   = 1'b1;
                            lk_data[p*DATA_W +: DATA_W] = st_data[l][s];
                        end else begin
                            lk_pending[p] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Writeback from the last stage; a stall suppresses the strobe so the held
    // packet is written exactly once, on the cycle it actually leaves.
    always_comb begin
        wbk_valid = '0;
        wbk_addr  = '0;
        wbk_data  = '0;
        for (int l = 0; l < LANES; l++) begin
            wbk_valid[l]                = st_valid[l][DEPTH-1] & st_wr_en[l][DEPTH-1] & ~bus.stall;
            wbk_addr[l*ADDR_W +: ADDR_W] = st_addr[l][DEPTH-1];
            wbk_data[l*DATA_W +: DATA_W] = st_data[l][DEPTH-1];
        end
    end

    assign bus.rd_hit     = lk_hit;
    assign bus.rd_pending = lk_pending;
    assign bus.rd_data    = lk_data;
    assign bus.wb_valid   = wbk_valid;
    assign bus.wb_addr    = wbk_addr;
    assign bus.wb_data    = wbk_data;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a packet-list model.
module tb_fwd_result_pipe;
    localparam int L  = 2;
    localparam int D  = 7;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int LW = 4;
    localparam int NR = 3;
    localparam int FS = 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    fwd_result_pipe_if #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW), .NUM_RD(NR)) bus ();
    fwd_result_pipe #(.LANES(L), .DEPTH(D), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW),
                      .NUM_RD(NR), .FLUSH_STAGES(FS)) dut (.clock(clock), .reset(reset), .bus(bus));

    fwd_result_pipe_if #(.LANES(4), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW), .NUM_RD(1)) bus2 ();
    fwd_result_pipe #(.LANES(4), .DEPTH(3), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW),
                      .NUM_RD(1), .FLUSH_STAGES(1)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    // Model: a list of live packets, each knowing its lane and current stage.
    typedef struct {
        int             lane;
        int             stage;
        bit             wr;
        int             addr;
        logic [DW-1:0]  data;
        int             lat;
    } pkt_t;

    pkt_t pipe[$];
    pkt_t nq[$];
    pkt_t tmp;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe.delete();
        end else begin
            nq.delete();
            foreach (pipe[i]) begin
                tmp = pipe[i];
                if (!bus.stall) tmp.stage = tmp.stage + 1;
                if (tmp.stage <= D && !(bus.flush && tmp.stage <= FS)) nq.push_back(tmp);
            end
            if (!bus.stall && !(bus.flush && FS >= 1)) begin
                for (int l = 0; l < L; l++) begin
                    if (bus.in_valid[l]) begin
                        tmp.lane  = l;
                        tmp.stage = 1;
                        tmp.wr    = bus.in_wr_en[l];
                        tmp.addr  = int'(bus.in_addr[l*AW +: AW]);
                        tmp.data  = bus.in_data[l*DW +: DW];
                        tmp.lat   = int'(bus.in_lat[l*LW +: LW]);
                        nq.push_back(tmp);
                    end
                end
            end
            pipe = nq;
        end
    end

    function automatic void model_lookup(input int a, output bit h, output bit pe,
                                         output logic [DW-1:0] d);
        int bi;
        int need;
        bi = -1;
        h = 1'b0;
        pe = 1'b0;
        d = '0;
        foreach (pipe[i]) begin
            if (pipe[i].wr && pipe[i].addr == a) begin
                if (bi < 0 || pipe[i].stage < pipe[bi].stage ||
                    (pipe[i].stage == pipe[bi].stage && pipe[i].lane > pipe[bi].lane)) bi = i;
            end
        end
        if (bi >= 0) begin
            need = (pipe[bi].lat > 1) ? pipe[bi].lat : 1;
            if (pipe[bi].stage >= need) begin
                h = 1'b1;
                d = pipe[bi].data;
            end else begin
                pe = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        bit            h;
        bit            pe;
        logic [DW-1:0] d;
        bit            ev;
        for (int p = 0; p < NR; p++) begin
            model_lookup(int'(bus.rd_addr[p*AW +: AW]), h, pe, d);
            chk("m_rd_hit", DW'(bus.rd_hit[p]), DW'(h));
            chk("m_rd_pending", DW'(bus.rd_pending[p]), DW'(pe));
            if (h || !pe) chk("m_rd_data", bus.rd_data[p*DW +: DW], d);
        end
        for (int l = 0; l < L; l++) begin
            ev = 1'b0;
            foreach (pipe[i]) begin
                if (pipe[i].lane == l && pipe[i].stage == D && pipe[i].wr && !bus.stall) begin
                    ev = 1'b1;
                    chk("m_wb_addr", DW'(bus.wb_addr[l*AW +: AW]), DW'(pipe[i].addr));
                    chk("m_wb_data", bus.wb_data[l*DW +: DW], pipe[i].data);
                end
            end
            chk("m_wb_valid", DW'(bus.wb_valid[l]), DW'(ev));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid = '0;
        bus.in_wr_en = '0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_lat   = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_pkt(input int lane, input int addr, input logic [DW-1:0] data, input int lat);
        bus.in_valid[lane]           = 1'b1;
        bus.in_wr_en[lane]           = 1'b1;
        bus.in_addr[lane*AW +: AW]   = AW'(addr);
        bus.in_data[lane*DW +: DW]   = data;
        bus.in_lat[lane*LW +: LW]    = LW'(lat);
    endtask

    task automatic set_rd(input int port, input int addr);
        bus.rd_addr[port*AW +: AW] = AW'(addr);
        #1;
    endtask

    task automatic drain();
        clear_in();
        repeat (D + 1) tick();
    endtask

    initial begin
        int a_at;
        int b_cnt;
        int pulses;
        clear_in();
        bus.rd_addr = '0;
        bus2.in_valid = '0;
        bus2.in_wr_en = '0;
        bus2.in_addr  = '0;
        bus2.in_data  = '0;
        bus2.in_lat   = '0;
        bus2.stall    = 1'b0;
        bus2.flush    = 1'b0;
        bus2.rd_addr  = '0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_wb_valid", DW'(bus.wb_valid), '0);
        chk("rst_rd_hit", DW'(bus.rd_hit), '0);
        reset = 1'b0;
        chk("rel_wb_valid", DW'(bus.wb_valid), '0);
        chk("rel_rd_data", bus.rd_data[DW-1:0], '0);

        // latency and writeback
        set_pkt(0, 8, 70, 2);
        tick();
        clear_in();
        set_rd(0, 8);
        chk("lat_pending_s1", DW'(bus.rd_pending[0]), 1);
        chk("lat_hit_s1", DW'(bus.rd_hit[0]), 0);
        tick();
        chk("lat_hit_s2", DW'(bus.rd_hit[0]), 1);
        chk("lat_data_s2", bus.rd_data[DW-1:0], 70);
        repeat (4) tick();
        chk("lat_wb_early", DW'(bus.wb_valid), 0);
        tick();
        chk("lat_wb_valid", DW'(bus.wb_valid), 1);
        chk("lat_wb_addr", DW'(bus.wb_addr[AW-1:0]), 8);
        chk("lat_wb_data", bus.wb_data[DW-1:0], 70);
        drain();

        // youngest-match priority
        set_pkt(0, 9, 11, 1);
        tick();
        clear_in();
        set_pkt(1, 9, 22, 3);
        tick();
        clear_in();
        set_rd(1, 9);
        chk("yng_pending", DW'(bus.rd_pending[1]), 1);
        chk("yng_no_hit", DW'(bus.rd_hit[1]), 0);
        tick();
        tick();
        chk("yng_hit", DW'(bus.rd_hit[1]), 1);
        chk("yng_data", bus.rd_data[DW +: DW], 22);
        set_pkt(0, 9, 33, 0);
        set_pkt(1, 9, 44, 0);
        tick();
        clear_in();
        #1;
        chk("tie_data_lane1", bus.rd_data[DW +: DW], 44);
        drain();

        // flush kills the younger packet only
        set_pkt(0, 20, 100, 1);
        tick();
        clear_in();
        set_pkt(0, 21, 200, 1);
        bus.flush = 1'b1;
        tick();
        clear_in();
        set_rd(2, 21);
        chk("fl_b_miss_hit", DW'(bus.rd_hit[2]), 0);
        chk("fl_b_miss_pend", DW'(bus.rd_pending[2]), 0);
        a_at = -1;
        b_cnt = 0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (bus.wb_valid[0] && bus.wb_addr[AW-1:0] == 20) a_at = k;
            if (bus.wb_valid[0] && bus.wb_addr[AW-1:0] == 21) b_cnt++;
        end
        chk("fl_a_retire_cycle", DW'(a_at), 7);
        chk("fl_b_never", DW'(b_cnt), 0);

        // stall while the packet sits in the last stage
        set_pkt(1, 30, 300, 1);
        tick();
        clear_in();
        set_rd(0, 30);
        repeat (6) tick();
        bus.stall = 1'b1;
        #1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            chk("st_wb_held", DW'(bus.wb_valid), 0);
            chk("st_hit", DW'(bus.rd_hit[0]), 1);
            chk("st_data", bus.rd_data[DW-1:0], 300);
            tick();
        end
        bus.stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.wb_valid[1] && bus.wb_addr[AW +: AW] == 30) pulses++;
            tick();
        end
        chk("st_one_pulse", DW'(pulses), 1);

        // reset mid-flight
        set_pkt(0, 50, 500, 0);
        tick();
        clear_in();
        set_pkt(1, 51, 510, 0);
        tick();
        clear_in();
        set_pkt(0, 52, 520, 0);
        tick();
        clear_in();
        reset = 1'b1;
        bus.rd_addr[0 +: AW] = 50;
        bus.rd_addr[AW +: AW] = 51;
        bus.rd_addr[2*AW +: AW] = 52;
        #1;
        chk("mid_rst_hit", DW'(bus.rd_hit), 0);
        chk("mid_rst_pend", DW'(bus.rd_pending), 0);
        chk("mid_rst_wb", DW'(bus.wb_valid), 0);
        tick();
        reset = 1'b0;
        pulses = 0;
        repeat (10) begin
            tick();
            if (bus.wb_valid != 0) pulses++;
        end
        chk("mid_rst_no_retire", DW'(pulses), 0);

        // parameter sweep instance: 4 lanes, 3 stages
        for (int l = 0; l < 4; l++) begin
            bus2.in_valid[l]         = 1'b1;
            bus2.in_wr_en[l]         = 1'b1;
            bus2.in_addr[l*AW +: AW] = AW'(40 + l);
            bus2.in_data[l*DW +: DW] = DW'(1000 + l);
            bus2.in_lat[l*LW +: LW]  = '0;
        end
        tick();
        bus2.in_valid = '0;
        bus2.rd_addr  = 42;
        #1;
        chk("sw_hit", DW'(bus2.rd_hit), 1);
        chk("sw_data", bus2.rd_data, 1002);
        tick();
        chk("sw_wb_early", DW'(bus2.wb_valid), 0);
        tick();
        chk("sw_wb_valid", DW'(bus2.wb_valid), 4'hF);
        for (int l = 0; l < 4; l++) begin
            chk("sw_wb_addr", DW'(bus2.wb_addr[l*AW +: AW]), DW'(40 + l));
            chk("sw_wb_data", bus2.wb_data[l*DW +: DW], DW'(1000 + l));
        end
        tick();
        chk("sw_wb_after", DW'(bus2.wb_valid), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < L; l++) begin
                bus.in_valid[l]         = ($urandom % 3) != 0;
                bus.in_wr_en[l]         = ($urandom % 4) != 0;
                bus.in_addr[l*AW +: AW] = AW'($urandom % 8);
                bus.in_data[l*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                bus.in_lat[l*LW +: LW]  = LW'($urandom % 11);
            end
            bus.stall = ($urandom % 5) == 0;
            bus.flush = ($urandom % 12) == 0;
            for (int p = 0; p < NR; p++) bus.rd_addr[p*AW +: AW] = AW'($urandom % 8);
            tick();
        end
        clear_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
